// File: rtl/conv_mac_seq.sv
// conv_mac_seq
//   Multiply-accumulate sequencer for the convolution engine. After a CLR
//   pulse and a start pulse from the start controller it walks the
//   KSIZE x KSIZE kernel window one tap per cycle, accumulating signed
//   pixel*weight products, then pulses done for one cycle.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   CLR       in   synchronous clear: zeroes acc/tap, aborts any pass
//   start     in   begin one window pass (honoured in IDLE only)
//   pix_in    in   signed pixel for current tap_addr (same-cycle read)
//   wgt_in    in   signed weight for current tap_addr (same-cycle read)
//   tap_addr  out  current tap index 0..N-1, registered
//   acc_out   out  signed accumulator (wraps modulo 2^ACC_W), registered
//   busy      out  high while in RUN, registered
//   done      out  one-cycle pulse after the last tap is accumulated
module conv_mac_seq #(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 3,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CLR,
  input  logic              start,
  input  logic [DATA_W-1:0] pix_in,
  input  logic [DATA_W-1:0] wgt_in,
  output logic [7:0]        tap_addr,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned N    = KSIZE * KSIZE;
  localparam logic [7:0]  LAST = 8'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Full-precision signed product, sign-extended to the accumulator width.
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  always_comb begin
    prod     = $signed(pix_in) * $signed(wgt_in);
    prod_ext = ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tap_addr <= '0;
      acc_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (CLR) begin
      // CLR outranks everything, including a same-cycle start.
      state    <= IDLE;
      tap_addr <= '0;
      acc_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          tap_addr <= '0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc_out <= acc_out + $unsigned(prod_ext);
          if (tap_addr == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            tap_addr <= tap_addr + 8'd1;
          end
        end
        DONE: begin
          // start arriving here is dropped, not queued.
          state    <= IDLE;
          done     <= 1'b0;
          tap_addr <= '0;
        end
        default: begin
          state    <= IDLE;
          tap_addr <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_seq.sv
module tb_conv_mac_seq;

  localparam int N = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       CLR;
  logic       start;
  logic [7:0] pix_in;
  logic [7:0] wgt_in;

  logic [7:0]  tap20, tap16;
  logic [19:0] acc20;
  logic [15:0] acc16;
  logic        busy20, busy16, done20, done16;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_mac_seq #(.DATA_W(8), .KSIZE(3), .ACC_W(20)) u20 (
    .clk(clk), .rst(rst), .CLR(CLR), .start(start),
    .pix_in(pix_in), .wgt_in(wgt_in),
    .tap_addr(tap20), .acc_out(acc20), .busy(busy20), .done(done20)
  );

  conv_mac_seq #(.DATA_W(8), .KSIZE(3), .ACC_W(16)) u16 (
    .clk(clk), .rst(rst), .CLR(CLR), .start(start),
    .pix_in(pix_in), .wgt_in(wgt_in),
    .tap_addr(tap16), .acc_out(acc16), .busy(busy16), .done(done16)
  );

  typedef struct {
    logic [7:0]  pix;
    logic [7:0]  wgt;
    bit          clr;
    logic [19:0] e20;
    logic [15:0] e16;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("clr_acc20", {12'd0, acc20}, 32'd0);
    chk("clr_acc16", {16'd0, acc16}, 32'd0);
    chk("clr_tap", {24'd0, tap20}, 32'd0);
    chk("clr_busy", {31'd0, busy20}, 32'd0);
  endtask

  task automatic run_pass(input logic [7:0] p, input logic [7:0] w, input bit doclr,
                          input logic [19:0] e20, input logic [15:0] e16);
    pix_in = p;
    wgt_in = w;
    if (doclr) pulse_clr();
    start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    chk("e0_busy", {31'd0, busy20}, 32'd1);
    chk("e0_tap", {24'd0, tap20}, 32'd0);
    chk("e0_done", {31'd0, done20}, 32'd0);
    for (int k = 1; k < N; k++) begin
      tick();
      chk("run_tap", {24'd0, tap20}, k);
      chk("run_busy_done", {30'd0, busy20, done20}, 32'd2);
    end
    tick();                       // E0+N
    chk("fin_done", {30'd0, done20, done16}, 32'd3);
    chk("fin_busy", {31'd0, busy20}, 32'd0);
    chk("fin_acc20", {12'd0, acc20}, {12'd0, e20});
    chk("fin_acc16", {16'd0, acc16}, {16'd0, e16});
    tick();                       // E0+N+1
    chk("post_done", {31'd0, done20}, 32'd0);
    chk("post_tap", {24'd0, tap20}, 32'd0);
    chk("post_acc20", {12'd0, acc20}, {12'd0, e20});
  endtask

  initial begin
    int dones;
    int done_at;
    int busy_late;

    tbl[0] = '{8'd1,    8'd2,    1'b1, 20'd18,     16'd18};
    tbl[1] = '{8'hFD,   8'd5,    1'b1, 20'hFFF79,  16'hFF79};
    tbl[2] = '{8'hFD,   8'd5,    1'b0, 20'hFFEF2,  16'hFEF2};
    tbl[3] = '{8'hFD,   8'd5,    1'b1, 20'hFFF79,  16'hFF79};
    tbl[4] = '{8'h80,   8'h80,   1'b1, 20'h24000,  16'h4000};
    tbl[5] = '{8'd127,  8'h80,   1'b1, 20'hDC480,  16'hC480};
    tbl[6] = '{8'd7,    8'd11,   1'b0, 20'hDC735,  16'hC735};

    rst = 1'b1; CLR = 1'b0; start = 1'b0; pix_in = '0; wgt_in = '0;
    #2;
    chk("rst_outputs", {acc20[3:0], tap20[3:0], 6'd0, busy20, done20}, 32'd0);
    chk("rst_acc20", {12'd0, acc20}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy20}, 32'd0);

    for (int i = 0; i < 7; i++)
      run_pass(tbl[i].pix, tbl[i].wgt, tbl[i].clr, tbl[i].e20, tbl[i].e16);

    // CLR mid-run at tap 4: pass aborted, no done.
    pix_in = 8'd1; wgt_in = 8'd2;
    pulse_clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("abort_tap_before", {24'd0, tap20}, 32'd4);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("abort_acc", {12'd0, acc20}, 32'd0);
    chk("abort_tap", {24'd0, tap20}, 32'd0);
    chk("abort_busy", {31'd0, busy20}, 32'd0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (done20) dones++;
      tick();
    end
    chk("abort_no_done", dones, 32'd0);
    run_pass(8'd1, 8'd2, 1'b0, 20'd18, 16'd18);

    // start during RUN (tap 3) and during DONE is ignored.
    pulse_clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0; done_at = -1; busy_late = 0;
    for (int i = 0; i < 20; i++) begin
      start = ((busy20 && tap20 == 8'd3) || done20) ? 1'b1 : 1'b0;
      tick();
      if (done20) begin
        dones++;
        if (done_at < 0) done_at = i;
      end
      if (done_at >= 0 && busy20) busy_late++;
    end
    start = 1'b0;
    chk("ign_dones", dones, 32'd1);
    chk("ign_done_at", done_at, 32'd8);
    chk("ign_no_restart", busy_late, 32'd0);
    chk("ign_acc", {12'd0, acc20}, 32'd18);

    // CLR and start together: CLR wins.
    CLR = 1'b1; start = 1'b1;
    tick();
    CLR = 1'b0; start = 1'b0;
    chk("coll_busy", {31'd0, busy20}, 32'd0);
    chk("coll_acc", {12'd0, acc20}, 32'd0);
    tick();
    tick();
    chk("coll_idle", {30'd0, busy20, done20}, 32'd0);

    // Asynchronous reset mid-cycle during RUN.
    pix_in = 8'd1; wgt_in = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("arst_pre_busy", {31'd0, busy20}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_acc20", {12'd0, acc20}, 32'd0);
    chk("arst_acc16", {16'd0, acc16}, 32'd0);
    chk("arst_tap", {24'd0, tap20}, 32'd0);
    chk("arst_busy_done", {28'd0, busy20, done20, busy16, done16}, 32'd0);
    tick();
    rst = 1'b0;
    busy_late = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (busy20 || done20) busy_late++;
    end
    chk("arst_idle_holds", busy_late, 32'd0);
    run_pass(8'd1, 8'd2, 1'b0, 20'd18, 16'd18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
